// File: rtl/lfsr_bist_ctrl.sv
// BIST sequencer for a dual-LFSR compare datapath: flush, stream pattern, check mismatch flag over a LAT-aligned window.
// Optional macro LFSR_BIST_FIRST_FAIL_EN enables capture of the first failing RUN bit index on o_first_fail.
module lfsr_bist_ctrl #(
  parameter int          RUN_LEN   = 256,
  parameter int          FLUSH_LEN = 16,
  parameter int          LAT       = 2,
  parameter int          ERR_W     = 8,
  parameter logic [7:0]  SEED      = 8'hA5
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_result,
  output logic             o_ce,
  output logic             o_data,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [ERR_W-1:0] o_err_count,
  output logic [15:0]      o_first_fail
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FLUSH = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state, state_nx;
  logic [15:0]      cnt;
  logic [7:0]       lfsr;
  logic [LAT-1:0]   pipe, pipe_nx;
  logic             checked, hit, accept, active_nx;
  logic [ERR_W-1:0] err_nx;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (i_start) state_nx = S_FLUSH;
      S_FLUSH: if (cnt == 16'(FLUSH_LEN - 1)) state_nx = S_RUN;
      S_RUN:   if (cnt == 16'(RUN_LEN - 1)) state_nx = S_DRAIN;
      S_DRAIN: if (cnt == 16'(LAT - 1)) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    // Abort beats everything, including a simultaneous start in IDLE.
    if (i_abort) state_nx = S_IDLE;
  end

  // Tag pipe: bit 0 marks "this cycle drove a RUN bit"; the tag reaches
  // the top exactly when that bit's mismatch flag arrives.
  always_comb begin
    pipe_nx    = '0;
    pipe_nx[0] = (state == S_RUN);
    for (int i = 1; i < LAT; i++) pipe_nx[i] = pipe[i-1];
  end

  assign accept    = (state == S_IDLE) && i_start && !i_abort;
  assign checked   = pipe[LAT-1];
  assign hit       = checked && i_result;
  assign err_nx    = (hit && (o_err_count != '1)) ? o_err_count + ERR_W'(1) : o_err_count;
  assign active_nx = (state_nx == S_FLUSH) || (state_nx == S_RUN) || (state_nx == S_DRAIN);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      lfsr        <= SEED;
      pipe        <= '0;
      o_ce        <= 1'b0;
      o_data      <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_pass      <= 1'b0;
      o_err_count <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= ((state_nx != state) || (state_nx == S_IDLE)) ? 16'd0 : cnt + 16'd1;
      o_ce   <= active_nx;
      o_busy <= active_nx;
      o_data <= (state_nx == S_RUN) ? lfsr[7] : 1'b0;
      o_done <= (state_nx == S_DONE);
      if (state_nx == S_RUN) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

      if (state == S_IDLE) begin
        pipe <= '0;
        if (accept) begin
          lfsr        <= SEED;
          o_err_count <= '0;
          o_pass      <= 1'b0;
        end
      end else if (i_abort) begin
        pipe   <= '0;
        o_pass <= 1'b0;
      end else begin
        pipe        <= pipe_nx;
        o_err_count <= err_nx;
        // Include the final check landing on the last DRAIN cycle.
        if (state_nx == S_DONE) o_pass <= (err_nx == '0);
      end
    end
  end

`ifdef LFSR_BIST_FIRST_FAIL_EN
  logic [15:0] bit_idx;

  // 16'hFFFF doubles as "no failure yet"; a RUN index never reaches it.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      bit_idx      <= '0;
      o_first_fail <= '0;
    end else if (accept) begin
      bit_idx      <= '0;
      o_first_fail <= 16'hFFFF;
    end else if ((state != S_IDLE) && !i_abort && checked) begin
      bit_idx <= bit_idx + 16'd1;
      if (i_result && (o_first_fail == 16'hFFFF)) o_first_fail <= bit_idx;
    end
  end
`else
  assign o_first_fail = 16'd0;
`endif

endmodule

// File: tb/tb_lfsr_bist_ctrl.sv
// Directed bench for lfsr_bist_ctrl: scoreboard of expected pattern bits and end-of-test results.
module tb_lfsr_bist_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, abort, result;
  logic ce, data, busy, done, pass;
  logic [7:0]  err;
  logic [15:0] ff;
  logic ce4, data4, busy4, done4, pass4;
  logic [3:0]  err4;
  logic [15:0] ff4;

  lfsr_bist_ctrl dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_abort(abort), .i_result(result),
    .o_ce(ce), .o_data(data), .o_busy(busy), .o_done(done), .o_pass(pass),
    .o_err_count(err), .o_first_fail(ff));

  lfsr_bist_ctrl #(.ERR_W(4)) dut4 (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_abort(abort), .i_result(result),
    .o_ce(ce4), .o_data(data4), .o_busy(busy4), .o_done(done4), .o_pass(pass4),
    .o_err_count(err4), .o_first_fail(ff4));

  typedef struct {
    logic [7:0]  err;
    logic [3:0]  err4;
    logic        pass;
    logic [15:0] ff;
  } exp_t;

  exp_t exp_q[$];
  logic data_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  localparam int BUSY_CYC = 16 + 256 + 2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    assert (got === want) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
  endtask

  // mode 0: clean; 1: errors on RUN bits 5..7; 2: errors only in FLUSH and first LAT RUN cycles; 3: always 1
  function automatic logic result_at(input int mode, input int k);
    case (mode)
      1:       return (k >= 24) && (k <= 26);
      2:       return (k >= 1) && (k <= 18);
      3:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic push_expect(input int mode);
    logic [7:0] l;
    int         n;
    exp_t       e;
    l = 8'hA5;
    for (int i = 0; i < 256; i++) begin
      data_q.push_back(l[7]);
      l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    end
    n    = 0;
    e.ff = 16'hFFFF;
    // RUN bit j is driven in cycle 17+j and its result is sampled in cycle 19+j
    for (int k = 19; k <= 274; k++) begin
      if (result_at(mode, k)) begin
        if (n == 0) e.ff = 16'(k - 19);
        n++;
      end
    end
    e.err  = (n > 255) ? 8'd255 : 8'(n);
    e.err4 = (n > 15) ? 4'd15 : 4'(n);
    e.pass = (n == 0);
`ifndef LFSR_BIST_FIRST_FAIL_EN
    e.ff = 16'd0;
`endif
    exp_q.push_back(e);
  endtask

  task automatic run_test(input int mode);
    logic       got_done;
    logic       want_bit;
    logic       exp_busy;
    logic [7:0] first8;
    exp_t       e;
    first8   = 8'hA5;
    got_done = 1'b0;
    push_expect(mode);
    start  = 1'b1;
    result = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      exp_busy = (k <= BUSY_CYC);
      check("busy", busy, exp_busy);
      check("ce", ce, exp_busy);
      check("done", done, (k == BUSY_CYC + 1));
      check("ctl4", {ce4, busy4, done4}, {exp_busy, exp_busy, (k == BUSY_CYC + 1)});
      if (k >= 17 && k <= 272) begin
        want_bit = data_q.pop_front();
        check("data", data, want_bit);
        check("data4", data4, want_bit);
        if (k < 25) check("data_seed", data, first8[7 - (k - 17)]);
      end else begin
        check("data_idle", data, 1'b0);
      end
      if (done) begin
        got_done = 1'b1;
        e = exp_q.pop_front();
        check("err", err, e.err);
        check("err4", err4, e.err4);
        check("pass", pass, e.pass);
        check("pass4", pass4, e.pass);
        check("first_fail", ff, e.ff);
        check("first_fail4", ff4, e.ff);
        break;
      end
      result = result_at(mode, k);
      @(negedge clk);
    end
    check("done_seen", got_done, 1'b1);
    result = 1'b0;
    @(negedge clk);
    check("idle_after_done", {busy, ce, done}, 3'b000);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; result = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outs", {ce, data, busy, done, pass, err, ff}, '0);
    check("rst_outs4", {ce4, data4, busy4, done4, pass4, err4, ff4}, '0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_outs", {ce, data, busy, done, pass, err, ff}, '0);
    end

    run_test(0);
    check("clean_pass", pass, 1'b1);
    check("clean_err", err, 8'd0);
    run_test(1);
    check("bits567_err", err, 8'd3);
    check("bits567_pass", pass, 1'b0);
`ifdef LFSR_BIST_FIRST_FAIL_EN
    check("bits567_ff", ff, 16'd5);
`endif
    run_test(2);
    check("no_false_err", err, 8'd0);
    check("no_false_pass", pass, 1'b1);
    run_test(3);
    check("sat_err4", err4, 4'd15);
    check("sat_err8", err, 8'd255);
    check("sat_pass", pass4, 1'b0);

    // Abort at RUN bit 100 after errors on bits 10 and 20; a mid-test start must be ignored.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 117; k++) begin
      check("abort_busy", busy, 1'b1);
      result = (k == 29) || (k == 39);
      start  = (k == 50);
      abort  = (k == 117);
      @(negedge clk);
    end
    abort = 1'b0; start = 1'b0; result = 1'b0;
    check("abort_ctl", {busy, ce, data, done}, 4'b0000);
    check("abort_pass", pass, 1'b0);
    check("abort_err", err, 8'd2);
    check("abort_err4", err4, 4'd2);
`ifdef LFSR_BIST_FIRST_FAIL_EN
    check("abort_ff", ff, 16'd10);
`endif
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_abort", {busy, ce, done}, 3'b000);
    end

    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("start_abort_busy", {busy, ce}, 2'b00);
    check("start_abort_err", err, 8'd2);
    check("start_abort_ff", ff4, ff);

    // Asynchronous reset in the middle of RUN.
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    result = 1'b1;
    repeat (40) @(negedge clk);
    check("pre_reset_err", (err != 8'd0), 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst", {ce, data, busy, done, pass, err, ff}, '0);
    check("async_rst4", {ce4, data4, busy4, done4, pass4, err4, ff4}, '0);
    result = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_idle", {busy, ce, done}, 3'b000);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
